four_bit_down_timer: RTL and testbench
======================================

// Module: four_bit_down_timer
// PURPOSE
//   Loadable down-counter/timer: the count-down counterpart of the free-running up counter.
//   Counts a programmed value down to zero at a prescaled rate.
//   On reaching zero, it pulses terminal-count (tc), then either auto-reloads or stops in DONE.
//   Used as the delay/timeout source for control FSMs elsewhere in the design.
// PARAMETERS
//   WIDTH     4  counter and load-value width in bits
//   PRESCALE  1  clk cycles per decrement tick; must be >= 1 (1 = tick every cycle)
// PORTS
//   clk        in   1      rising-edge clock; the only clock
//   reset_n    in   1      reset; synchronous, active-low
//   load       in   1      capture load_val into reload_reg and into q
//   load_val   in   WIDTH  value to count down from
//   start      in   1      begin or restart counting from reload_reg
//   stop       in   1      halt counting; q holds its value
//   reload_en  in   1      1 = auto-reload at zero, 0 = one-shot
//   q          out  WIDTH  current count (registered)
//   busy       out  1      high while state==RUN
//   done       out  1      high while state==DONE (one-shot expired)
//   tc         out  1      one-cycle terminal-count pulse (registered)
// BEHAVIOUR
//   Reset, sampled at posedge when reset_n==0, sets:
//     q=0, reload_reg=0, prescale count=0, state=IDLE, busy=0, done=0, tc=0.
//   Reset overrides all other inputs.
//   Tick: asserted in RUN when prescale count == PRESCALE-1.
//     The prescale count wraps to 0 on a tick.
//     The prescale count is cleared on start, load, stop, and on leaving RUN.
//   States: IDLE, RUN, DONE.
//     IDLE --start--> RUN;  RUN --stop--> IDLE;
//     RUN --tick & q==0 & !reload_en--> DONE;  DONE --start--> RUN;  DONE --load--> IDLE.
//   Priority per cycle (after reset): load > stop > start > tick.
//     load: reload_reg<=load_val, q<=load_val.
//       If start is also high, next state is RUN; otherwise the state is kept (DONE->IDLE).
//       Any concurrent stop is ignored.
//     stop (no load): next state IDLE, q holds. stop wins over start.
//     start (no load/stop): q<=reload_reg, next state RUN. Restarts if already in RUN.
//     tick & q!=0: q<=q-1.
//     tick & q==0: tc<=1. If reload_en, q<=reload_reg and stay in RUN; else go to DONE, q stays 0.
//   Timing:
//     tc is high for exactly the one cycle after the edge that sampled q==0 on a tick;
//     it is 0 in every other cycle.
//     Period with reload is (reload_reg+1)*PRESCALE cycles.
//     load_val=0 followed by start gives tc on the first tick.
//   q never decrements below 0: there is no underflow wrap.
//   busy and done decode the registered state, with no combinational path from inputs.
//   Reset asserted mid-run returns all outputs to their reset values on the next edge.
// STRUCTURE
//   Package four_bit_down_timer_pkg:
//     state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
//     Function computing the prescale counter width: max(1, $clog2(PRESCALE)).
//   Sub-module tick_prescaler (clk, reset_n, en, clr -> tick):
//     For PRESCALE==1, tick = en.
//   Top level holds the FSM, q, reload_reg and tc registers.
// TESTING
//   1. Hold reset_n=0 for 2 cycles with load=start=1 -> q=0, busy=done=tc=0.
//   2. One-shot, PRESCALE=1: load_val=3, load, then start, reload_en=0
//      -> q=3,2,1,0 on consecutive cycles; tc=1 for one cycle; done=1, busy=0; q holds 0.
//   3. Auto-reload: load_val=2, reload_en=1, start
//      -> q=2,1,0,2,1,0...; tc every 3rd cycle; busy stays 1; done=0.
//   4. PRESCALE=4: load_val=1, start -> q=1 for 4 cycles, then 0 for 4 cycles;
//      tc one cycle, 8 cycles after start.
//   5. Stop/restart: stop when q=5 -> q stays 5, busy=0;
//      then start -> q=reload_reg (0xF) and counting resumes.
//   6. Collisions: load+start with load_val=0xA -> RUN with q=0xA;
//      stop+start -> IDLE; reset_n=0 during RUN -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/four_bit_down_timer_pkg.sv
// rtl/four_bit_down_timer_pkg.sv - shared types and helpers for the loadable down timer
package four_bit_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Prescale counter width; never below one bit so the register always exists.
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into one-cycle decrement ticks while enabled
module tick_prescaler
    import four_bit_down_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = prescale_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    // With PRESCALE==1 the count never leaves zero, so tick simply follows en.
    assign w_tick = en && (r_cnt == LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr || !en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/four_bit_down_timer.sv
// rtl/four_bit_down_timer.sv - loadable prescaled down timer with terminal-count pulse and auto-reload
module four_bit_down_timer
    import four_bit_down_timer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             reload_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             w_tick;
    logic             w_clr;
    logic             w_q_zero;

    assign w_q_zero = (r_q == '0);
    assign w_clr    = load || stop || start || ((r_state == ST_RUN) && (w_next != ST_RUN));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (r_state == ST_RUN),
        .clr     (w_clr),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority: load > stop > start > tick.
    always_comb begin
        w_next = r_state;
        if (load) begin
            if (start) begin
                w_next = ST_RUN;
            end else if (r_state == ST_DONE) begin
                w_next = ST_IDLE;
            end
        end else if (stop) begin
            w_next = ST_IDLE;
        end else if (start) begin
            w_next = ST_RUN;
        end else if (w_tick && w_q_zero && !reload_en) begin
            w_next = ST_DONE;
        end
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_reload <= load_val;
                r_q      <= load_val;
            end else if (!stop) begin
                if (start) begin
                    r_q <= r_reload;
                end else if (w_tick) begin
                    if (!w_q_zero) begin
                        r_q <= r_q - WIDTH'(1);
                    end else begin
                        r_tc <= 1'b1;
                        if (reload_en) begin
                            r_q <= r_reload;
                        end
                    end
                end
            end
        end
    end

    assign q  = r_q;
    assign tc = r_tc;

endmodule

// File: tb/tb_four_bit_down_timer.sv
// tb/tb_four_bit_down_timer.sv - self-checking bench for four_bit_down_timer at PRESCALE 1 and 4
module tb_four_bit_down_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       reload_en = 1'b0;

    logic [3:0] q1, q4;
    logic       busy1, done1, tc1, busy4, done4, tc4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    four_bit_down_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .reload_en(reload_en), .q(q1), .busy(busy1), .done(done1), .tc(tc1)
    );

    four_bit_down_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .reload_en(reload_en), .q(q4), .busy(busy4), .done(done4), .tc(tc4)
    );

    // Reference model: state 0=idle 1=run 2=done; m_pc counts cycles since the last tick.
    int m_q[2], m_rl[2], m_pc[2], m_st[2], m_tc[2];
    int ps[2] = '{1, 4};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_q[k] = 0; m_rl[k] = 0; m_pc[k] = 0; m_st[k] = 0; m_tc[k] = 0;
            end else begin
                m_tc[k] = 0;
                if (load) begin
                    m_rl[k] = load_val; m_q[k] = load_val; m_pc[k] = 0;
                    if (start) m_st[k] = 1;
                    else if (m_st[k] == 2) m_st[k] = 0;
                end else if (stop) begin
                    m_st[k] = 0; m_pc[k] = 0;
                end else if (start) begin
                    m_q[k] = m_rl[k]; m_st[k] = 1; m_pc[k] = 0;
                end else if (m_st[k] == 1) begin
                    if (m_pc[k] == ps[k] - 1) begin
                        m_pc[k] = 0;
                        if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
                        else begin
                            m_tc[k] = 1;
                            if (reload_en) m_q[k] = m_rl[k];
                            else m_st[k] = 2;
                        end
                    end else begin
                        m_pc[k] = m_pc[k] + 1;
                    end
                end
            end
        end
    end

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 1'b1; start = 1'b1; load_val = 4'hF;
        cycle(2);
        n_tests++;
        if ({q1, busy1, done1, tc1} !== 7'b0) begin
            n_fail++; $display("FAIL reset_p1 got=%b exp=%b", {q1, busy1, done1, tc1}, 7'b0);
        end
        n_tests++;
        if ({q4, busy4, done4, tc4} !== 7'b0) begin
            n_fail++; $display("FAIL reset_p4 got=%b exp=%b", {q4, busy4, done4, tc4}, 7'b0);
        end
        idle_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_oneshot();
        int exp_q[4] = '{3, 2, 1, 0};
        reload_en = 1'b0; load = 1'b1; load_val = 4'd3;
        cycle(1);
        load = 1'b0; start = 1'b1;
        cycle(1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({q1, busy1, done1, tc1} !== {4'(exp_q[i]), 3'b100}) begin
                n_fail++; $display("FAIL oneshot_q[%0d] got=%h/%b%b%b exp=%0d/100", i, q1, busy1, done1, tc1, exp_q[i]);
            end
            cycle(1);
        end
        n_tests++;
        if ({q1, busy1, done1, tc1} !== 7'b0000011) begin
            n_fail++; $display("FAIL oneshot_tc got=%b exp=0000011", {q1, busy1, done1, tc1});
        end
        cycle(1);
        n_tests++;
        if ({q1, busy1, done1, tc1} !== 7'b0000010) begin
            n_fail++; $display("FAIL oneshot_hold got=%b exp=0000010", {q1, busy1, done1, tc1});
        end
    endtask

    task automatic test_autoreload();
        load = 1'b1; load_val = 4'd2;
        cycle(1);
        load = 1'b0; start = 1'b1; reload_en = 1'b1;
        cycle(1);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_tests++;
            if ({q1, busy1, done1, tc1} !== {4'(2 - (i % 3)), 2'b10, (i > 0 && i % 3 == 0)}) begin
                n_fail++; $display("FAIL autoreload[%0d] got=%h/%b%b%b exp_q=%0d", i, q1, busy1, done1, tc1, 2 - (i % 3));
            end
            cycle(1);
        end
    endtask

    task automatic test_prescale4();
        reload_en = 1'b0; load = 1'b1; start = 1'b1; load_val = 4'd1;
        cycle(1);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({q4, busy4, tc4} !== {4'(i < 4 ? 1 : 0), 2'b10}) begin
                n_fail++; $display("FAIL prescale4[%0d] got=%h/%b%b exp_q=%0d", i, q4, busy4, tc4, i < 4 ? 1 : 0);
            end
            cycle(1);
        end
        n_tests++;
        if ({q4, busy4, done4, tc4} !== 7'b0000011) begin
            n_fail++; $display("FAIL prescale4_tc got=%b exp=0000011", {q4, busy4, done4, tc4});
        end
    endtask

    task automatic test_stop_restart();
        reload_en = 1'b0; load = 1'b1; start = 1'b1; load_val = 4'hF;
        cycle(1);
        idle_inputs();
        cycle(10);
        n_tests++;
        if ({q1, busy1} !== {4'd5, 1'b1}) begin
            n_fail++; $display("FAIL pre_stop got=%h/%b exp=5/1", q1, busy1);
        end
        stop = 1'b1;
        cycle(1);
        stop = 1'b0;
        cycle(3);
        n_tests++;
        if ({q1, busy1, done1, tc1} !== {4'd5, 3'b000}) begin
            n_fail++; $display("FAIL stop_hold got=%h/%b%b%b exp=5/000", q1, busy1, done1, tc1);
        end
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        n_tests++;
        if ({q1, busy1} !== {4'hF, 1'b1}) begin
            n_fail++; $display("FAIL restart got=%h/%b exp=f/1", q1, busy1);
        end
        cycle(1);
        n_tests++;
        if (q1 !== 4'hE) begin
            n_fail++; $display("FAIL resume got=%h exp=e", q1);
        end
    endtask

    task automatic test_collisions();
        load = 1'b1; start = 1'b1; stop = 1'b1; load_val = 4'hA;
        cycle(1);
        idle_inputs();
        n_tests++;
        if ({q1, busy1, done1} !== {4'hA, 2'b10}) begin
            n_fail++; $display("FAIL load_start got=%h/%b%b exp=a/10", q1, busy1, done1);
        end
        stop = 1'b1; start = 1'b1;
        cycle(1);
        idle_inputs();
        n_tests++;
        if ({q1, busy1, done1, tc1} !== {4'hA, 3'b000}) begin
            n_fail++; $display("FAIL stop_start got=%h/%b%b%b exp=a/000", q1, busy1, done1, tc1);
        end
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        cycle(2);
        reset_n = 1'b0;
        cycle(1);
        n_tests++;
        if ({q1, busy1, done1, tc1, q4, busy4, done4, tc4} !== 14'b0) begin
            n_fail++; $display("FAIL mid_reset got=%b exp=0", {q1, busy1, done1, tc1, q4, busy4, done4, tc4});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            load      = ($urandom_range(0, 9) == 0);
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            reload_en = ($urandom_range(0, 2) != 0);
            load_val  = 4'($urandom_range(0, 15));
            cycle(1);
            n_tests++;
            if ({q1, busy1, done1, tc1} !== {4'(m_q[0]), m_st[0] == 1, m_st[0] == 2, m_tc[0] == 1}) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL random_p1[%0d] got=%h/%b%b%b exp=%0d/st%0d/tc%0d", i, q1, busy1, done1, tc1, m_q[0], m_st[0], m_tc[0]);
            end
            n_tests++;
            if ({q4, busy4, done4, tc4} !== {4'(m_q[1]), m_st[1] == 1, m_st[1] == 2, m_tc[1] == 1}) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL random_p4[%0d] got=%h/%b%b%b exp=%0d/st%0d/tc%0d", i, q4, busy4, done4, tc4, m_q[1], m_st[1], m_tc[1]);
            end
        end
        idle_inputs();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_prescale4();
        test_stop_restart();
        test_collisions();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
